// File: rtl/vga_pixel_cmd_sink.sv
// Pixel-command sink: edge-detects writeEn on the HPS PIO word, clips and linearises the
// pixel address, queues accepted commands and drains them over a valid/ready port.
module vga_pixel_cmd_sink #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset_reset_n,
    input  logic [21:0]       cmd_word,
    output logic              fb_valid,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_colour,
    output logic              fb_mode,
    input  logic              clr_status,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count,
    output logic              busy
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTF_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef struct packed {
        logic       mode;
        logic       we;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] colour;
    } cmd_t;

    typedef struct packed {
        logic              mode;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        colour;
    } entry_t;

    cmd_t              in_q;
    logic              hist_we_q;
    logic              new_cmd_c;
    logic              in_range_c;
    logic              clip_drop_c;
    logic [ADDR_W-1:0] addr_c;
    entry_t            stg_d;
    entry_t            stg_q;
    logic              stg_vld_q;

    entry_t            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTF_W-1:0] cnt_q, cnt_d;
    logic              busy_q;
    logic              full_c;
    logic              pop_c;
    logic              push_c;
    logic              ovf_c;
    entry_t            head_c;

    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [SUM_W-1:0]  drop_sum_c;

    // writeEn history resets high so a level held through reset release is not an edge
    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            in_q      <= '0;
            in_q.we   <= 1'b1;
            hist_we_q <= 1'b1;
        end else begin
            in_q      <= cmd_word;
            hist_we_q <= in_q.we;
        end
    end

    // Clip to the active resolution and form y*W + x from shifts
    always_comb begin
        new_cmd_c = in_q.we & ~hist_we_q;
        if (in_q.mode) begin
            in_range_c = (in_q.x < 9'd320) && (in_q.y < 8'd240);
            addr_c     = (ADDR_W'(in_q.y) << 8) + (ADDR_W'(in_q.y) << 6) + ADDR_W'(in_q.x);
        end else begin
            in_range_c = (in_q.x < 9'd160) && (in_q.y < 8'd120);
            addr_c     = (ADDR_W'(in_q.y) << 7) + (ADDR_W'(in_q.y) << 5) + ADDR_W'(in_q.x);
        end
        clip_drop_c  = new_cmd_c & ~in_range_c;
        stg_d.mode   = in_q.mode;
        stg_d.addr   = addr_c;
        stg_d.colour = in_q.colour;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stg_vld_q <= 1'b0;
            stg_q     <= '0;
        end else begin
            stg_vld_q <= new_cmd_c & in_range_c;
            stg_q     <= stg_d;
        end
    end

    // A pop on the same edge frees a slot, so a full FIFO still accepts that push
    always_comb begin
        full_c = (cnt_q == CNTF_W'(FIFO_DEPTH));
        pop_c  = (cnt_q != '0) & fb_ready;
        push_c = stg_vld_q & (~full_c | pop_c);
        ovf_c  = stg_vld_q & full_c & ~pop_c;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            cnt_d = cnt_q + CNTF_W'(1);
        end else if (!push_c && pop_c) begin
            cnt_d = cnt_q - CNTF_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= (cnt_d != '0);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= stg_q;
        end
    end

    // Clipped and overflowed commands can land on the same edge, so the step is 0..2
    always_comb begin
        ovf_d      = ovf_q;
        drop_sum_c = SUM_W'(drop_q) + SUM_W'(clip_drop_c) + SUM_W'(ovf_c);
        drop_d     = drop_sum_c[SUM_W-1] ? '1 : drop_sum_c[CNT_W-1:0];
        if (ovf_c) begin
            ovf_d = 1'b1;
        end
        if (clr_status) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    assign head_c     = mem_q[rd_ptr_q];
    assign fb_valid   = busy_q;
    assign busy       = busy_q;
    assign fb_addr    = head_c.addr;
    assign fb_colour  = head_c.colour;
    assign fb_mode    = head_c.mode;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_vga_pixel_cmd_sink.sv
// Bench for vga_pixel_cmd_sink: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference model.
module tb_vga_pixel_cmd_sink;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned CNT_W  = 16;
    localparam int          DEPTH  = 8;
    localparam int          CNT_MAX = 65535;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [21:0]       cmd_word;
    logic              fb_valid;
    logic              fb_ready;
    logic [ADDR_W-1:0] fb_addr;
    logic [2:0]        fb_colour;
    logic              fb_mode;
    logic              clr_status;
    logic              overflow;
    logic [CNT_W-1:0]  drop_count;
    logic              busy;

    always #5 clk = ~clk;

    vga_pixel_cmd_sink #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLOCK_50      (clk),
        .reset_reset_n (rst_n),
        .cmd_word      (cmd_word),
        .fb_valid      (fb_valid),
        .fb_ready      (fb_ready),
        .fb_addr       (fb_addr),
        .fb_colour     (fb_colour),
        .fb_mode       (fb_mode),
        .clr_status    (clr_status),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    typedef struct {
        int addr;
        int colour;
        int mode;
    } xact_t;

    int    n_chk = 0;
    int    n_bad = 0;
    int    xfers = 0;

    // Reference model state
    xact_t mq[$];
    bit    m_prev_we;
    bit    m_det_vld;
    int    m_det_mode, m_det_x, m_det_y, m_det_col;
    bit    m_stg_vld;
    xact_t m_stg;
    bit    m_ovf;
    int    m_drops;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [21:0] mk(input int mode, input int we, input int x, input int y, input int c);
        return {1'(mode), 1'(we), 9'(x), 8'(y), 3'(c)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_prev_we = 1'b1;
        m_det_vld = 1'b0;
        m_stg_vld = 1'b0;
        m_ovf     = 1'b0;
        m_drops   = 0;
    endtask

    // One clock edge: pop, then the command detected two edges ago enters the queue,
    // the one detected last edge is clipped, and the sampled word is edge-detected.
    task automatic model_edge(input logic [21:0] w, input bit rdy, input bit clr);
        bit full, pop;
        int wl, hl;
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (m_stg_vld) begin
            if (full && !pop) begin
                m_ovf = 1'b1;
                m_drops++;
            end else begin
                mq.push_back(m_stg);
            end
        end
        m_stg_vld = 1'b0;
        if (m_det_vld) begin
            wl = m_det_mode ? 320 : 160;
            hl = m_det_mode ? 240 : 120;
            if (m_det_x < wl && m_det_y < hl) begin
                m_stg_vld     = 1'b1;
                m_stg.addr    = m_det_y * wl + m_det_x;
                m_stg.colour  = m_det_col;
                m_stg.mode    = m_det_mode;
            end else begin
                m_drops++;
            end
        end
        m_det_vld  = w[20] && !m_prev_we;
        m_det_mode = int'(w[21]);
        m_det_x    = int'(w[19:11]);
        m_det_y    = int'(w[10:3]);
        m_det_col  = int'(w[2:0]);
        m_prev_we  = w[20];
        if (m_drops > CNT_MAX) m_drops = CNT_MAX;
        if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
    endtask

    task automatic compare();
        chk("valid", int'(fb_valid), int'(mq.size() > 0));
        chk("busy", int'(busy), int'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("addr", int'(fb_addr), mq[0].addr);
            chk("colour", int'(fb_colour), mq[0].colour);
            chk("mode", int'(fb_mode), mq[0].mode);
        end
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("drops", int'(drop_count), m_drops);
    endtask

    task automatic tick();
        bit xf;
        xf = fb_valid && fb_ready;
        @(posedge clk);
        if (xf) xfers++;
        model_edge(cmd_word, fb_ready, clr_status);
        #1;
        compare();
    endtask

    task automatic send(input int mode, input int x, input int y, input int c);
        cmd_word = mk(mode, 1, x, y, c);
        tick();
        cmd_word = mk(mode, 0, x, y, c);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", int'(fb_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_addr", int'(fb_addr), 0);
        chk("rst_colour", int'(fb_colour), 0);
        chk("rst_mode", int'(fb_mode), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drops", int'(drop_count), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    initial begin
        int mode, w, h, x, y;
        cmd_word   = '0;
        fb_ready   = 1'b1;
        clr_status = 1'b0;
        #1;
        do_reset();
        repeat (3) tick();

        // Corner pixel at full resolution, 2-edge latency, single cycle with ready high
        cmd_word = mk(1, 1, 319, 239, 5);
        tick();
        cmd_word = mk(1, 0, 319, 239, 5);
        tick();
        chk("t1_latency", int'(fb_valid), 0);
        tick();
        chk("t1_valid", int'(fb_valid), 1);
        chk("t1_addr", int'(fb_addr), 76799);
        chk("t1_colour", int'(fb_colour), 5);
        chk("t1_mode", int'(fb_mode), 1);
        tick();
        chk("t1_once", int'(fb_valid), 0);

        // Clip at low resolution, then its last pixel
        send(0, 160, 10, 3);
        tick();
        chk("t2_drop", int'(drop_count), 1);
        chk("t2_ovf", int'(overflow), 0);
        chk("t2_novalid", int'(fb_valid), 0);
        cmd_word = mk(0, 1, 159, 119, 2);
        tick();
        cmd_word = mk(0, 0, 159, 119, 2);
        tick();
        tick();
        chk("t2_addr", int'(fb_addr), 19199);
        tick();

        // Ten commands into a stalled FIFO
        pulse_clr();
        fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(1, 10 + i, 20 + i, i % 8);
        repeat (3) tick();
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_drop", int'(drop_count), 2);
        xfers = 0;
        fb_ready = 1'b1;
        repeat (12) tick();
        chk("t3_xfers", xfers, 8);

        // writeEn held high: one command; held through reset release: none
        xfers = 0;
        cmd_word = mk(1, 1, 5, 6, 1);
        repeat (50) tick();
        chk("t4_hold", xfers, 1);
        do_reset();
        xfers = 0;
        repeat (10) tick();
        chk("t4_rst_hold", xfers, 0);
        cmd_word = mk(1, 0, 5, 6, 1);
        tick();

        // Push into a full FIFO on the same edge as a pop
        pulse_clr();
        fb_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(i % 2, 30 + i, 40 + i, 7 - i);
        tick();
        cmd_word = mk(1, 1, 100, 100, 6);
        tick();
        cmd_word = mk(1, 0, 100, 100, 6);
        tick();
        xfers = 0;
        fb_ready = 1'b1;
        tick();
        chk("t5_ovf", int'(overflow), 0);
        chk("t5_drop", int'(drop_count), 0);
        chk("t5_valid", int'(fb_valid), 1);
        repeat (12) tick();
        chk("t5_xfers", xfers, 9);

        // Reset with commands queued
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1, 200 + i, 100 + i, i);
        tick();
        chk("t6_busy", int'(busy), 1);
        do_reset();
        xfers = 0;
        fb_ready = 1'b1;
        repeat (10) tick();
        chk("t6_xfers", xfers, 0);

        // Random traffic biased toward the clip boundaries, stalls and clears
        for (int n = 0; n < 3000; n++) begin
            mode = int'($urandom_range(0, 1));
            w = mode ? 320 : 160;
            h = mode ? 240 : 120;
            case ($urandom_range(0, 3))
                0: x = int'($urandom_range(0, 511));
                1: x = w - 1;
                2: x = w;
                default: x = int'($urandom_range(0, w - 1));
            endcase
            case ($urandom_range(0, 3))
                0: y = int'($urandom_range(0, 255));
                1: y = h - 1;
                2: y = h;
                default: y = int'($urandom_range(0, h - 1));
            endcase
            cmd_word   = mk(mode, int'($urandom_range(0, 1)), x, y, int'($urandom_range(0, 7)));
            fb_ready   = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_status = ($urandom_range(0, 63) == 0);
            tick();
        end
        clr_status = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
